key_decimal_display: RTL and testbench

// - Read side of the key editor: turns a 32-bit key (n/e/d or the value being typed) into 10 decimal digits.
// - Conversion is sequential (shift-add-3, one bit per clock); the result is held stable between conversions.
// - A scan counter steps through the digits and presents one digit at a time, with blanking, to the 7-seg driver.
// - Blanking covers leading zeros and a blinking cursor on the digit being edited.

---
 rtl/key_disp_pkg.sv | 28 ++
 rtl/key_decimal_display_if.sv | 24 ++
 rtl/key_decimal_display_bin2bcd_seq.sv | 71 +++++++
 rtl/key_decimal_display.sv | 110 +++++++++++
 tb/tb_key_decimal_display.sv | 233 +++++++++++++++++++++++
 5 files changed

// File: rtl/key_disp_pkg.sv
// Shared key-display constants, conversion FSM states and digit helpers.
// Used by the key editor, the decimal display and the 7-seg driver.
package key_disp_pkg;
  localparam int DIGITS = 10;
  localparam int BCD_W  = 40;
  localparam int KEY_W  = 32;

  typedef enum logic [1:0] {
    CONV_IDLE   = 2'd0,
    CONV_SHIFT  = 2'd1,
    CONV_COMMIT = 2'd2
  } conv_state_t;

  // Index of the highest nonzero digit; 0 when every digit is zero.
  function automatic logic [3:0] msd_of(input logic [BCD_W-1:0] b);
    msd_of = 4'd0;
    for (int k = 0; k < DIGITS; k++) begin
      if (b[4*k +: 4] != 4'd0) msd_of = 4'(k);
    end
  endfunction

  function automatic logic [3:0] digit_at(input logic [BCD_W-1:0] b, input logic [3:0] idx);
    digit_at = 4'd0;
    for (int k = 0; k < DIGITS; k++) begin
      if (4'(k) == idx) digit_at = b[4*k +: 4];
    end
  endfunction
endpackage

// File: rtl/key_decimal_display_if.sv
// Key value in, converted digits and scanned digit out; slave is the display block.
interface key_decimal_display_if;
  import key_disp_pkg::*;

  logic [KEY_W-1:0] value;
  logic             cursor_en;
  logic [3:0]       cursor;
  logic [BCD_W-1:0] bcd;
  logic             bcd_valid;
  logic             busy;
  logic [3:0]       scan_idx;
  logic [3:0]       scan_bcd;
  logic             scan_blank;

  modport master (
    output value, cursor_en, cursor,
    input  bcd, bcd_valid, busy, scan_idx, scan_bcd, scan_blank
  );

  modport slave (
    input  value, cursor_en, cursor,
    output bcd, bcd_valid, busy, scan_idx, scan_bcd, scan_blank
  );
endinterface

// File: rtl/key_decimal_display_bin2bcd_seq.sv
// Sequential shift-add-3 binary to BCD: start in IDLE, KEY_W shift cycles, one commit cycle.
// Result register is written only at commit; start is ignored while busy.
module bin2bcd_seq
  import key_disp_pkg::*;
#(
  parameter int KEY_W = key_disp_pkg::KEY_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_i,
  input  logic [KEY_W-1:0] bin_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [BCD_W-1:0] bcd_o
);
  localparam int SRW = BCD_W + KEY_W;
  localparam int CW  = $clog2(KEY_W);

  conv_state_t      state_q;
  logic [SRW-1:0]   sr_q;
  logic [SRW-1:0]   sr_d;
  logic [SRW-1:0]   adj;
  logic [CW-1:0]    cnt_q;
  logic             busy_q;
  logic [BCD_W-1:0] bcd_q;

  always_comb begin
    adj = sr_q;
    for (int k = 0; k < BCD_W / 4; k++) begin
      if (adj[KEY_W + 4*k +: 4] >= 4'd5)
        adj[KEY_W + 4*k +: 4] = adj[KEY_W + 4*k +: 4] + 4'd3;
    end
    sr_d = adj << 1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= CONV_IDLE;
      sr_q    <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      bcd_q   <= '0;
    end else begin
      case (state_q)
        CONV_IDLE: begin
          if (start_i) begin
            sr_q    <= {{BCD_W{1'b0}}, bin_i};
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= CONV_SHIFT;
          end
        end
        CONV_SHIFT: begin
          sr_q  <= sr_d;
          cnt_q <= cnt_q + CW'(1);
          if (cnt_q == CW'(KEY_W - 1)) state_q <= CONV_COMMIT;
        end
        CONV_COMMIT: begin
          bcd_q   <= sr_q[SRW-1 -: BCD_W];
          busy_q  <= 1'b0;
          state_q <= CONV_IDLE;
        end
        default: state_q <= CONV_IDLE;
      endcase
    end
  end

  assign busy_o = busy_q;
  assign done_o = (state_q == CONV_COMMIT);
  assign bcd_o  = bcd_q;
endmodule

// File: rtl/key_decimal_display.sv
// Key to 10 decimal digits (33 cycles per conversion) with a scanned, blanked digit output.
// Conversion restarts whenever the key differs from the last one converted; no backpressure.
module key_decimal_display
  import key_disp_pkg::*;
#(
  parameter int SCAN_DIV  = 100000,
  parameter int BLINK_DIV = 25000000
) (
  input  logic clk,
  input  logic rst,
  key_decimal_display_if.slave kif
);
  localparam int SCW = $clog2(SCAN_DIV + 1);
  localparam int BCW = $clog2(BLINK_DIV + 1);

  logic [BCD_W-1:0] bcd;
  logic             busy;
  logic             done;
  logic             start;
  logic [KEY_W-1:0] last_q;
  logic             pending_q;
  logic             bcd_valid_q;

  logic [SCW-1:0]   scan_cnt_q;
  logic [3:0]       scan_idx_q;
  logic [3:0]       scan_bcd_q;
  logic             scan_blank_q;
  logic [BCW-1:0]   blink_cnt_q;
  logic             phase_on_q;

  logic             scan_wrap;
  logic [3:0]       idx_d;
  logic [3:0]       msd;
  logic [3:0]       curs_lim;
  logic             lead;
  logic             blink;
  logic             blank_d;

  assign start = !busy && (pending_q || kif.value != last_q);

  bin2bcd_seq #(.KEY_W(KEY_W)) u_conv (
    .clk     (clk),
    .rst     (rst),
    .start_i (start),
    .bin_i   (kif.value),
    .busy_o  (busy),
    .done_o  (done),
    .bcd_o   (bcd)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      last_q      <= '0;
      pending_q   <= 1'b1;
      bcd_valid_q <= 1'b0;
    end else if (start) begin
      last_q      <= kif.value;
      pending_q   <= 1'b0;
      bcd_valid_q <= 1'b0;
    end else if (done) begin
      bcd_valid_q <= 1'b1;
    end
  end

  assign scan_wrap = (scan_cnt_q == SCW'(SCAN_DIV - 1));

  // Blanking is evaluated for the digit that will be presented after this edge.
  always_comb begin
    idx_d = scan_idx_q;
    if (scan_wrap) idx_d = (scan_idx_q == 4'(DIGITS - 1)) ? 4'd0 : scan_idx_q + 4'd1;
    msd      = msd_of(bcd);
    curs_lim = (kif.cursor > 4'd9) ? 4'd9 : kif.cursor;
    lead     = (idx_d > msd) && !(kif.cursor_en && idx_d <= curs_lim);
    blink    = kif.cursor_en && (kif.cursor <= 4'd9) && (idx_d == kif.cursor) && !phase_on_q;
    blank_d  = lead || blink || !bcd_valid_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      scan_cnt_q   <= '0;
      scan_idx_q   <= 4'd0;
      scan_bcd_q   <= 4'd0;
      scan_blank_q <= 1'b0;
    end else begin
      scan_cnt_q   <= scan_wrap ? '0 : scan_cnt_q + SCW'(1);
      scan_idx_q   <= idx_d;
      scan_bcd_q   <= digit_at(bcd, idx_d);
      scan_blank_q <= blank_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || !kif.cursor_en) begin
      blink_cnt_q <= '0;
      phase_on_q  <= 1'b1;
    end else if (blink_cnt_q == BCW'(BLINK_DIV - 1)) begin
      blink_cnt_q <= '0;
      phase_on_q  <= !phase_on_q;
    end else begin
      blink_cnt_q <= blink_cnt_q + BCW'(1);
    end
  end

  assign kif.bcd        = bcd;
  assign kif.bcd_valid  = bcd_valid_q;
  assign kif.busy       = busy;
  assign kif.scan_idx   = scan_idx_q;
  assign kif.scan_bcd   = scan_bcd_q;
  assign kif.scan_blank = scan_blank_q;
endmodule

// File: tb/tb_key_decimal_display.sv
// Bench for key_decimal_display: conversion results scored from a queue, scan and blink checked inline.
module tb_key_decimal_display;
  import key_disp_pkg::*;

  localparam int SCAN_DIV  = 2;
  localparam int BLINK_DIV = 8;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  key_decimal_display_if kif ();

  key_decimal_display #(.SCAN_DIV(SCAN_DIV), .BLINK_DIV(BLINK_DIV)) dut (
    .clk (clk),
    .rst (rst),
    .kif (kif)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int ecount  = 0;
  int last_commit = 0;

  always @(posedge clk) ecount <= ecount + 1;

  typedef struct {
    logic [39:0] bcd;
    int          edge_n;
  } exp_t;
  exp_t sb_q[$];
  logic prev_valid = 1'b0;

  // Scoreboard: every rise of bcd_valid must match the oldest expected commit.
  always @(negedge clk) begin
    if (kif.bcd_valid === 1'b1 && prev_valid !== 1'b1) begin
      if (sb_q.size() == 0) begin
        n_tests++; n_fail++;
        $display("FAIL sb_unexpected: commit at edge %0d bcd=%h, none expected", ecount, kif.bcd);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        n_tests++;
        if (kif.bcd !== e.bcd) begin
          n_fail++;
          $display("FAIL sb_bcd: got %h, expected %h", kif.bcd, e.bcd);
        end
        n_tests++;
        if (ecount != e.edge_n) begin
          n_fail++;
          $display("FAIL sb_latency: commit at edge %0d, expected edge %0d", ecount, e.edge_n);
        end
      end
    end
    prev_valid = kif.bcd_valid;
  end

  task automatic wait_at(input int n);
    while (ecount < n) @(negedge clk);
  endtask

  task automatic wait_sb(input int budget);
    int k = 0;
    while (sb_q.size() != 0 && k < budget) begin
      @(negedge clk);
      k++;
    end
    @(negedge clk);
    if (sb_q.size() != 0) begin
      n_tests++; n_fail++;
      $display("FAIL sb_timeout: %0d results still pending after %0d cycles", sb_q.size(), budget);
      sb_q.delete();
    end
  endtask

  task automatic test_reset();
    int t;
    logic [3:0] prev, exp_idx;
    int steps, k;
    rst = 1'b1; kif.value = '0; kif.cursor_en = 1'b0; kif.cursor = 4'd0;
    repeat (3) @(negedge clk);
    n_tests++; if (kif.bcd !== 40'h0)      begin n_fail++; $display("FAIL rst_bcd: got %h, expected 0", kif.bcd); end
    n_tests++; if (kif.bcd_valid !== 1'b0) begin n_fail++; $display("FAIL rst_valid: got %b, expected 0", kif.bcd_valid); end
    n_tests++; if (kif.busy !== 1'b0)      begin n_fail++; $display("FAIL rst_busy: got %b, expected 0", kif.busy); end
    n_tests++; if (kif.scan_idx !== 4'd0)  begin n_fail++; $display("FAIL rst_scan_idx: got %0d, expected 0", kif.scan_idx); end
    n_tests++; if (kif.scan_blank !== 1'b0) begin n_fail++; $display("FAIL rst_blank: got %b, expected 0", kif.scan_blank); end
    t = ecount + 1;
    rst = 1'b0;
    sb_q.push_back('{40'h0, t + 33});
    wait_at(t);
    n_tests++; if (kif.busy !== 1'b1) begin n_fail++; $display("FAIL first_busy_rise: got %b, expected 1", kif.busy); end
    wait_at(t + 32);
    n_tests++; if (kif.busy !== 1'b1) begin n_fail++; $display("FAIL first_busy_last: got %b, expected 1", kif.busy); end
    n_tests++; if (kif.bcd_valid !== 1'b0) begin n_fail++; $display("FAIL first_valid_early: got %b, expected 0", kif.bcd_valid); end
    wait_at(t + 33);
    n_tests++; if (kif.busy !== 1'b0) begin n_fail++; $display("FAIL first_busy_fall: got %b, expected 0", kif.busy); end
    wait_sb(10);
    last_commit = t + 33;
    // Zero shows a single units digit; everything above it is dark.
    prev = kif.scan_idx; steps = 0; k = 0;
    while (steps < 12 && k < 200) begin
      @(negedge clk); k++;
      if (kif.scan_idx !== prev) begin
        exp_idx = (prev == 4'd9) ? 4'd0 : prev + 4'd1;
        n_tests++; if (kif.scan_idx !== exp_idx) begin n_fail++; $display("FAIL zero_scan_idx: got %0d, expected %0d", kif.scan_idx, exp_idx); end
        n_tests++; if (kif.scan_bcd !== 4'd0) begin n_fail++; $display("FAIL zero_scan_bcd idx%0d: got %0d, expected 0", exp_idx, kif.scan_bcd); end
        n_tests++; if (kif.scan_blank !== (exp_idx != 4'd0)) begin n_fail++; $display("FAIL zero_blank idx%0d: got %b, expected %b", exp_idx, kif.scan_blank, exp_idx != 4'd0); end
        prev = kif.scan_idx; steps++;
      end
    end
    if (steps < 12) begin n_tests++; n_fail++; $display("FAIL zero_scan_timeout: %0d of 12 steps seen", steps); end
  endtask

  task automatic test_max_value();
    int t;
    kif.value = 32'hFFFF_FFFF;
    t = ecount + 1;
    sb_q.push_back('{40'h4294967295, t + 33});
    wait_at(t + 32);
    n_tests++; if (kif.busy !== 1'b1) begin n_fail++; $display("FAIL max_busy_last: got %b, expected 1", kif.busy); end
    n_tests++; if (kif.bcd !== 40'h0) begin n_fail++; $display("FAIL max_old_bcd_held: got %h, expected 0", kif.bcd); end
    wait_at(t + 33);
    n_tests++; if (kif.busy !== 1'b0) begin n_fail++; $display("FAIL max_busy_fall: got %b, expected 0", kif.busy); end
    wait_sb(10);
    last_commit = t + 33;
  endtask

  task automatic test_back_to_back();
    int t;
    kif.value = 32'd1234567890;
    t = ecount + 1;
    sb_q.push_back('{40'h1234567890, t + 33});
    sb_q.push_back('{40'h0000000305, t + 67});
    wait_at(t + 10);
    kif.value = 32'd305;
    wait_at(t + 33);
    n_tests++; if (kif.busy !== 1'b0) begin n_fail++; $display("FAIL b2b_idle_gap: got busy %b, expected 0", kif.busy); end
    wait_at(t + 34);
    n_tests++; if (kif.busy !== 1'b1) begin n_fail++; $display("FAIL b2b_restart: got busy %b, expected 1", kif.busy); end
    n_tests++; if (kif.bcd_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_valid_drop: got %b, expected 0", kif.bcd_valid); end
    wait_sb(100);
    last_commit = t + 67;
  endtask

  task automatic test_blanking();
    logic [3:0] dig [10];
    logic [3:0] prev, exp_idx;
    logic       exp_blank;
    int steps, k, e, seen_on, seen_off;
    dig = '{4'd5, 4'd0, 4'd3, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0};
    // Phase 1: no edit, leading zeros above digit 2 are dark.
    prev = kif.scan_idx; steps = 0; k = 0;
    while (steps < 12 && k < 200) begin
      @(negedge clk); k++;
      if (kif.scan_idx !== prev) begin
        exp_idx = (prev == 4'd9) ? 4'd0 : prev + 4'd1;
        n_tests++; if (kif.scan_idx !== exp_idx) begin n_fail++; $display("FAIL lead_scan_idx: got %0d, expected %0d", kif.scan_idx, exp_idx); end
        n_tests++; if (kif.scan_bcd !== dig[exp_idx]) begin n_fail++; $display("FAIL lead_scan_bcd idx%0d: got %0d, expected %0d", exp_idx, kif.scan_bcd, dig[exp_idx]); end
        n_tests++; if (kif.scan_blank !== (exp_idx > 4'd2)) begin n_fail++; $display("FAIL lead_blank idx%0d: got %b, expected %b", exp_idx, kif.scan_blank, exp_idx > 4'd2); end
        prev = kif.scan_idx; steps++;
      end
    end
    if (steps < 12) begin n_tests++; n_fail++; $display("FAIL lead_scan_timeout: %0d of 12 steps seen", steps); end
    // Phase 2: cursor on digit 5; digits 3..4 light, digit 5 blinks from the on phase.
    kif.cursor_en = 1'b1; kif.cursor = 4'd5;
    e = ecount; steps = 0; k = 0; seen_on = 0; seen_off = 0;
    while (steps < 80 && k < 400) begin
      @(negedge clk); k++;
      if (kif.scan_idx !== prev) begin
        exp_idx = (prev == 4'd9) ? 4'd0 : prev + 4'd1;
        if (exp_idx == 4'd5) begin
          exp_blank = (((ecount - 1 - e) / BLINK_DIV) % 2) == 1;
          if (exp_blank) seen_off++; else seen_on++;
        end else begin
          exp_blank = exp_idx > 4'd5;
        end
        n_tests++; if (kif.scan_bcd !== dig[exp_idx]) begin n_fail++; $display("FAIL cur_scan_bcd idx%0d: got %0d, expected %0d", exp_idx, kif.scan_bcd, dig[exp_idx]); end
        n_tests++; if (kif.scan_blank !== exp_blank) begin n_fail++; $display("FAIL cur_blank idx%0d edge %0d: got %b, expected %b", exp_idx, ecount, kif.scan_blank, exp_blank); end
        prev = kif.scan_idx; steps++;
      end
    end
    n_tests++; if (seen_on == 0)  begin n_fail++; $display("FAIL blink_on_seen: got %0d shown, expected >0", seen_on); end
    n_tests++; if (seen_off == 0) begin n_fail++; $display("FAIL blink_off_seen: got %0d dark, expected >0", seen_off); end
    // Phase 3: out-of-range cursor acts as 9 for leading zeros, no blink at all.
    kif.cursor = 4'd12;
    steps = 0; k = 0;
    while (steps < 20 && k < 200) begin
      @(negedge clk); k++;
      if (kif.scan_idx !== prev) begin
        exp_idx = (prev == 4'd9) ? 4'd0 : prev + 4'd1;
        n_tests++; if (kif.scan_blank !== 1'b0) begin n_fail++; $display("FAIL cur12_blank idx%0d: got %b, expected 0", exp_idx, kif.scan_blank); end
        prev = kif.scan_idx; steps++;
      end
    end
    if (steps < 20) begin n_tests++; n_fail++; $display("FAIL cur12_scan_timeout: %0d of 20 steps seen", steps); end
    kif.cursor_en = 1'b0; kif.cursor = 4'd0;
  endtask

  task automatic test_reset_mid_conversion();
    int t, t2;
    kif.value = 32'd777;
    t = ecount + 1;
    wait_at(t + 5);
    rst = 1'b1;
    wait_at(t + 6);
    n_tests++; if (kif.bcd !== 40'h0)      begin n_fail++; $display("FAIL midrst_bcd: got %h, expected 0", kif.bcd); end
    n_tests++; if (kif.bcd_valid !== 1'b0) begin n_fail++; $display("FAIL midrst_valid: got %b, expected 0", kif.bcd_valid); end
    n_tests++; if (kif.busy !== 1'b0)      begin n_fail++; $display("FAIL midrst_busy: got %b, expected 0", kif.busy); end
    n_tests++; if (kif.scan_idx !== 4'd0)  begin n_fail++; $display("FAIL midrst_scan_idx: got %0d, expected 0", kif.scan_idx); end
    rst = 1'b0;
    t2 = t + 7;
    sb_q.push_back('{40'h0000000777, t2 + 33});
    wait_at(t2 + 32);
    n_tests++; if (kif.busy !== 1'b1) begin n_fail++; $display("FAIL midrst_reconvert_busy: got %b, expected 1", kif.busy); end
    wait_sb(60);
  endtask

  initial begin
    test_reset();
    test_max_value();
    test_back_to_back();
    test_blanking();
    test_reset_mid_conversion();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, %0d failed so far", n_fail);
    $fatal(1, "timeout");
  end
endmodule
